// File: rtl/adc_unpack.sv
// adc_unpack: fetches 32-bit packed peak-sample words from the capture FIFO
// and replays them as a ready/valid stream of 8-bit samples with a 0-based
// index within the frame. Byte 0 ([7:0]) of each word is the oldest sample.
// A frame is started by i_sync; i_sync beats i_abort, which beats normal flow.
// One FIFO word is in flight at most; there is no prefetch of the next word.

module adc_unpack #(
  parameter int unsigned LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sync,
  input  logic [LEN_W-1:0] i_frame_len,
  input  logic             i_abort,
  input  logic             i_empty,
  output logic             o_rd_req,
  input  logic [31:0]      i_rd_data,
  input  logic             i_rd_vld,
  output logic [7:0]       o_sample,
  output logic [LEN_W-1:0] o_sample_idx,
  output logic             o_sample_vld,
  input  logic             i_sample_rdy,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UNPACK = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       sample_q, sample_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             rd_req_q, rd_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] cnt_inc;

  // Select one byte lane of the held word; lane 0 is the earliest sample.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] p);
    logic [7:0] b;
    case (p)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  assign cnt_inc = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

  // Next-state and next-output decode; sync and abort override every state.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    word_d   = word_q;
    sample_d = sample_q;
    idx_d    = idx_q;
    vld_d    = vld_q;
    rd_req_d = 1'b0;
    done_d   = 1'b0;
    if (i_sync) begin
      len_d    = i_frame_len;
      cnt_d    = {LEN_W{1'b0}};
      ptr_d    = 2'd0;
      word_d   = 32'd0;
      sample_d = 8'd0;
      idx_d    = {LEN_W{1'b0}};
      vld_d    = 1'b0;
      if (i_frame_len == {LEN_W{1'b0}}) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_FETCH;
      end
    end else if (i_abort) begin
      state_d = ST_IDLE;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_FETCH: begin
          if (!i_empty) begin
            rd_req_d = 1'b1;
            state_d  = ST_WAIT;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (i_rd_vld) begin
            word_d   = i_rd_data;
            ptr_d    = 2'd0;
            sample_d = i_rd_data[7:0];
            idx_d    = cnt_q;
            vld_d    = 1'b1;
            state_d  = ST_UNPACK;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_UNPACK: begin
          if (vld_q && i_sample_rdy) begin
            cnt_d = cnt_inc;
            ptr_d = ptr_q + 2'd1;
            if (cnt_inc == len_q) begin
              // Last sample of the frame; leftover bytes in the word are dropped.
              vld_d   = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else if (ptr_q == 2'd3) begin
              vld_d   = 1'b0;
              state_d = ST_FETCH;
            end else begin
              sample_d = pick_byte(word_q, ptr_q + 2'd1);
              idx_d    = cnt_inc;
              state_d  = ST_UNPACK;
            end
          end else begin
            state_d = ST_UNPACK;
          end
        end
        ST_DONE: begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= {LEN_W{1'b0}};
      cnt_q    <= {LEN_W{1'b0}};
      ptr_q    <= 2'd0;
      word_q   <= 32'd0;
      sample_q <= 8'd0;
      idx_q    <= {LEN_W{1'b0}};
      vld_q    <= 1'b0;
      rd_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      word_q   <= word_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      rd_req_q <= rd_req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_rd_req     = rd_req_q;
  assign o_sample     = sample_q;
  assign o_sample_idx = idx_q;
  assign o_sample_vld = vld_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_adc_unpack.sv
// Self-checking bench for adc_unpack. A FIFO model answers read requests with
// a configurable latency; the expected stream of each frame is the first len
// bytes (little-endian lanes) of the words loaded for it.

module tb_adc_unpack;
  localparam int LEN_W = 12;

  logic             clk, rst_n, i_sync, i_abort, i_empty, o_rd_req, i_rd_vld;
  logic             o_sample_vld, i_sample_rdy, o_busy, o_done;
  logic [LEN_W-1:0] i_frame_len, o_sample_idx;
  logic [31:0]      i_rd_data;
  logic [7:0]       o_sample;

  int               n_checks, n_errors;
  logic [31:0]      fifo_q[$];
  logic [31:0]      exp_w[$];
  logic [7:0]       got_s[$];
  logic [LEN_W-1:0] got_i[$];
  int               done_cnt, rd_cnt, hs_cyc, done_cyc, cyc, wk;
  bit               force_empty, stale_req, lat_rnd;

  adc_unpack #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_sync(i_sync), .i_frame_len(i_frame_len),
    .i_abort(i_abort), .i_empty(i_empty), .o_rd_req(o_rd_req),
    .i_rd_data(i_rd_data), .i_rd_vld(i_rd_vld), .o_sample(o_sample),
    .o_sample_idx(o_sample_idx), .o_sample_vld(o_sample_vld),
    .i_sample_rdy(i_sample_rdy), .o_busy(o_busy), .o_done(o_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_word(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_w.push_back(w);
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = exp_w[i / 4];
    return w[8 * (i % 4) +: 8];
  endfunction

  function automatic logic next_rdy(input bit rnd);
    return rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // FIFO read-port model: pops on o_rd_req, answers after 1..3 cycles.
  initial begin : responder
    bit          pend;
    int          lat;
    logic [31:0] word;
    pend = 1'b0; lat = 0; word = 32'd0;
    i_rd_vld = 1'b0; i_rd_data = 32'd0; i_empty = 1'b1;
    forever begin
      @(posedge clk); #2;
      i_rd_vld = 1'b0;
      if (stale_req) begin
        i_rd_vld  = 1'b1;
        i_rd_data = 32'hEEEE_EEEE;
        stale_req = 1'b0;
      end else if (pend) begin
        lat--;
        if (lat == 0) begin
          i_rd_vld  = 1'b1;
          i_rd_data = word;
          pend      = 1'b0;
        end
      end
      if (o_rd_req) begin
        if (fifo_q.size() > 0) word = fifo_q.pop_front();
        else word = 32'hDEAD_BEEF;
        pend = 1'b1;
        lat  = lat_rnd ? int'($urandom_range(1, 3)) : 1;
      end
      i_empty = force_empty || (fifo_q.size() == 0);
    end
  end

  // Output monitor: records accepted samples, done pulses and read requests.
  initial begin : monitor
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (o_sample_vld && i_sample_rdy) begin
        got_s.push_back(o_sample);
        got_i.push_back(o_sample_idx);
        hs_cyc = cyc;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_rd_req) rd_cnt++;
    end
  end

  task automatic clear_obs();
    got_s.delete(); got_i.delete();
    done_cnt = 0; rd_cnt = 0;
  endtask

  // Runs one frame against exp_w; optional stall, empty hold and abort.
  task automatic run_frame(input int len, input int stall_idx, input int empty_hold,
                           input int abort_at, input bit rnd, input bit do_sync);
    int         k, budget, stall_left;
    bit         stalled, aborted, fin;
    logic [7:0] hs;
    logic [LEN_W-1:0] hi;
    k = 0; stall_left = 0; stalled = 1'b0; aborted = 1'b0; fin = 1'b0;
    hs = 8'd0; hi = '0;
    budget = 40 * len + 200;
    lat_rnd = rnd;
    if (do_sync) begin
      clear_obs();
      force_empty = (empty_hold > 0);
      i_sample_rdy = 1'b1;
      @(posedge clk); #1;
      i_sync = 1'b1; i_frame_len = LEN_W'(len);
      @(posedge clk); #1;
      i_sync = 1'b0;
    end
    while (!fin && k < budget) begin
      if (stall_left > 0) begin
        check("stall_sample", o_sample, hs);
        check("stall_idx", o_sample_idx, hi);
        check("stall_vld", o_sample_vld, 1'b1);
        stall_left--;
        i_sample_rdy = (stall_left > 0) ? 1'b0 : next_rdy(rnd);
      end else if (!stalled && o_sample_vld && int'(o_sample_idx) == stall_idx) begin
        stalled = 1'b1; stall_left = 3;
        hs = o_sample; hi = o_sample_idx;
        i_sample_rdy = 1'b0;
      end else begin
        i_sample_rdy = next_rdy(rnd);
      end
      if (empty_hold > 0 && k <= empty_hold) begin
        check("empty_no_req", o_rd_req, 1'b0);
        force_empty = (k < empty_hold);
      end else if (empty_hold > 0 && k == empty_hold + 1) begin
        check("req_pulse", o_rd_req, 1'b1);
        force_empty = 1'b0;
      end else if (empty_hold > 0 && k == empty_hold + 2) begin
        check("req_single", o_rd_req, 1'b0);
        force_empty = 1'b0;
      end else begin
        force_empty = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
      end
      if (aborted && k == abort_at + 1) begin
        check("abort_vld", o_sample_vld, 1'b0);
        check("abort_busy", o_busy, 1'b0);
      end
      i_abort = (k == abort_at);
      if (k == abort_at) aborted = 1'b1;
      @(posedge clk); #1;
      k++;
      fin = (done_cnt > 0) || (aborted && k >= abort_at + 4);
    end
    i_abort = 1'b0; i_sample_rdy = 1'b1; force_empty = 1'b0;
    check("frame_end", fin, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    if (aborted) begin
      check("abort_no_done", done_cnt, 32'd0);
      check("abort_prefix", (got_s.size() <= len), 1'b1);
      fifo_q.delete();
    end else begin
      check("done_cnt", done_cnt, 32'd1);
      check("done_lat", done_cyc, hs_cyc + 1);
      check("rd_cnt", rd_cnt, (len + 3) / 4);
      check("n_samples", got_s.size(), len);
    end
    for (int i = 0; i < got_s.size() && i < len; i++) begin
      check("sample", got_s[i], exp_byte(i));
      check("index", got_i[i], i);
    end
    check("end_vld", o_sample_vld, 1'b0);
    check("end_busy", o_busy, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    done_cnt = 0; rd_cnt = 0; hs_cyc = 0; done_cyc = 0; wk = 0;
    rst_n = 1'b0; i_sync = 1'b0; i_frame_len = '0; i_abort = 1'b0;
    i_sample_rdy = 1'b0; force_empty = 1'b0; stale_req = 1'b0; lat_rnd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_req", o_rd_req, 1'b0);
    check("rst_sample", o_sample, 8'd0);
    check("rst_idx", o_sample_idx, 12'd0);
    check("rst_vld", o_sample_vld, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two full words, ready held high.
    exp_w.delete(); add_word(32'h4433_2211); add_word(32'h8877_6655);
    run_frame(8, -1, 0, -1, 1'b0, 1'b1);

    // Frame ends mid-word; remaining bytes dropped.
    exp_w.delete(); add_word(32'h4433_2211); add_word(32'hDDCC_BB55);
    run_frame(5, -1, 0, -1, 1'b0, 1'b1);

    // Back-pressure on idx 1 for three cycles.
    exp_w.delete(); add_word(32'h4433_2211);
    run_frame(4, 1, 0, -1, 1'b0, 1'b1);

    // FIFO empty for 10 cycles after sync.
    exp_w.delete(); add_word(32'h1357_9BDF);
    run_frame(4, -1, 10, -1, 1'b0, 1'b1);

    // Resync at idx 2 of an 8-sample frame, then a stale read response.
    exp_w.delete(); add_word(32'h4433_2211); add_word(32'h8877_6655);
    clear_obs(); lat_rnd = 1'b0; i_sample_rdy = 1'b1;
    @(posedge clk); #1; i_sync = 1'b1; i_frame_len = 12'd8;
    @(posedge clk); #1; i_sync = 1'b0;
    wk = 0;
    while (!(o_sample_vld && o_sample_idx == 12'd2) && wk < 100) begin
      @(posedge clk); #1; wk++;
    end
    check("resync_reach", (wk < 100), 1'b1);
    check("resync_old_s2", o_sample, 8'h33);
    fifo_q.delete(); force_empty = 1'b1;
    exp_w.delete(); add_word(32'hD4C3_B2A1);
    i_sync = 1'b1; i_frame_len = 12'd4;
    @(posedge clk); #1; i_sync = 1'b0;
    clear_obs();
    check("resync_vld_drop", o_sample_vld, 1'b0);
    check("resync_busy", o_busy, 1'b1);
    stale_req = 1'b1;
    @(posedge clk); #1;
    check("stale_ignored", o_sample_vld, 1'b0);
    run_frame(4, -1, 0, -1, 1'b0, 1'b0);

    // Zero-length frame.
    clear_obs();
    @(posedge clk); #1; i_sync = 1'b1; i_frame_len = 12'd0;
    @(posedge clk); #1; i_sync = 1'b0;
    check("zero_done", o_done, 1'b1);
    check("zero_vld", o_sample_vld, 1'b0);
    @(posedge clk); #1;
    check("zero_done_pulse", o_done, 1'b0);
    check("zero_idle", o_busy, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("zero_no_req", rd_cnt, 32'd0);
    check("zero_done_cnt", done_cnt, 32'd1);

    // Abort mid-frame.
    exp_w.delete();
    for (int w = 0; w < 4; w++) add_word($urandom());
    run_frame(16, -1, 0, 10, 1'b1, 1'b1);

    // Reset mid-frame.
    exp_w.delete();
    for (int w = 0; w < 8; w++) add_word($urandom());
    clear_obs(); i_sample_rdy = 1'b0;
    @(posedge clk); #1; i_sync = 1'b1; i_frame_len = 12'd32;
    @(posedge clk); #1; i_sync = 1'b0;
    wk = 0;
    while (!o_sample_vld && wk < 100) begin @(posedge clk); #1; wk++; end
    check("rstmid_reach", (wk < 100), 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid_rd_req", o_rd_req, 1'b0);
    check("rstmid_sample", o_sample, 8'd0);
    check("rstmid_idx", o_sample_idx, 12'd0);
    check("rstmid_vld", o_sample_vld, 1'b0);
    check("rstmid_busy", o_busy, 1'b0);
    check("rstmid_done", o_done, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1; i_sample_rdy = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    fifo_q.delete();
    check("rstmid_no_done", done_cnt, 32'd0);
    check("rstmid_idle", o_busy, 1'b0);

    // Boundary lengths and randomized frames.
    exp_w.delete(); add_word($urandom());
    run_frame(1, -1, 0, -1, 1'b1, 1'b1);
    exp_w.delete(); add_word($urandom());
    run_frame(4, -1, 0, -1, 1'b1, 1'b1);
    for (int f = 0; f < 16; f++) begin
      int len;
      int st;
      len = int'($urandom_range(1, 40));
      st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
      exp_w.delete();
      for (int w = 0; w < (len + 3) / 4; w++) add_word($urandom());
      run_frame(len, st, 0, -1, 1'b1, 1'b1);
    end
    exp_w.delete();
    for (int w = 0; w < 1024; w++) add_word($urandom());
    run_frame(4095, -1, 0, -1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
